// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between dcache and icache with tag-ownership routing and an icache starvation guard
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      proc2Dmem_command,
  input  logic [XLEN-1:0] proc2Dmem_addr,
  input  logic [63:0]     proc2Dmem_data,
  input  logic [1:0]      proc2Imem_command,
  input  logic [XLEN-1:0] proc2Imem_addr,
  output logic [3:0]      Dmem2proc_response,
  output logic [3:0]      Dmem2proc_tag,
  output logic [63:0]     Dmem2proc_data,
  output logic [3:0]      Imem2proc_response,
  output logic [3:0]      Imem2proc_tag,
  output logic [63:0]     Imem2proc_data,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [3:0]      mem2proc_tag,
  input  logic [63:0]     mem2proc_data,
  output logic            orphan_tag_err
);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_cnt;
  logic [15:0] valid, owner_i;
  logic orphan, d_req, i_req, gnt_d, gnt_i, hit, miss;
  logic [1:0] gnt_cmd;
  assign d_req = proc2Dmem_command != BUS_NONE;
  assign i_req = proc2Imem_command != BUS_NONE;
  assign gnt_i = i_req && (starve_cnt == LIMIT || !d_req);
  assign gnt_d = d_req && !gnt_i;
  assign gnt_cmd = gnt_d ? proc2Dmem_command : gnt_i ? proc2Imem_command : BUS_NONE;
  assign hit = mem2proc_tag != 4'd0 && valid[mem2proc_tag];
  assign miss = mem2proc_tag != 4'd0 && !valid[mem2proc_tag];
  assign proc2mem_command = reset ? gnt_cmd : BUS_NONE;
  assign proc2mem_addr = gnt_i ? proc2Imem_addr : proc2Dmem_addr;
  assign proc2mem_data = gnt_i ? 64'd0 : proc2Dmem_data;
  assign Dmem2proc_response = reset && gnt_d ? mem2proc_response : 4'd0;
  assign Imem2proc_response = reset && gnt_i ? mem2proc_response : 4'd0;
  assign Dmem2proc_tag = reset && hit && !owner_i[mem2proc_tag] ? mem2proc_tag : 4'd0;
  assign Imem2proc_tag = reset && hit && owner_i[mem2proc_tag] ? mem2proc_tag : 4'd0;
  assign Dmem2proc_data = mem2proc_data;
  assign Imem2proc_data = mem2proc_data;
  assign orphan_tag_err = orphan;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      owner_i <= '0;
      starve_cnt <= '0;
      orphan <= 1'b0;
    end else begin
      if (hit) valid[mem2proc_tag] <= 1'b0;
      if (miss) orphan <= 1'b1;
      if (gnt_cmd == BUS_LOAD && mem2proc_response != 4'd0) begin
        valid[mem2proc_response] <= 1'b1;
        owner_i[mem2proc_response] <= gnt_i;
      end
      starve_cnt <= i_req && gnt_d ? starve_cnt + SW'(starve_cnt != LIMIT) : '0;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors plus a per-cycle ownership/starvation model for mem_arbiter
module tb_mem_arbiter;
  localparam int LIM = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [1:0] dcmd, icmd, pcmd;
  logic [31:0] daddr, iaddr, paddr;
  logic [63:0] ddata, mdata, pdata, d_data, i_data;
  logic [3:0] mresp, mtag, d_resp, d_tag, i_resp, i_tag;
  logic orphan;
  int vectors = 0;
  int miscompares = 0;
  int owner_of [16];
  int denied = 0;
  bit orph_m = 1'b0;

  mem_arbiter #(.STARVE_LIMIT(LIM), .XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .proc2Dmem_command(dcmd), .proc2Dmem_addr(daddr), .proc2Dmem_data(ddata),
    .proc2Imem_command(icmd), .proc2Imem_addr(iaddr),
    .Dmem2proc_response(d_resp), .Dmem2proc_tag(d_tag), .Dmem2proc_data(d_data),
    .Imem2proc_response(i_resp), .Imem2proc_tag(i_tag), .Imem2proc_data(i_data),
    .proc2mem_command(pcmd), .proc2mem_addr(paddr), .proc2mem_data(pdata),
    .mem2proc_response(mresp), .mem2proc_tag(mtag), .mem2proc_data(mdata),
    .orphan_tag_err(orphan)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  function automatic int who_wins();
    if (icmd != 2'd0 && denied >= LIM) return 2;
    if (dcmd != 2'd0) return 1;
    if (icmd != 2'd0) return 2;
    return 0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) owner_of[i] <= 0;
      denied <= 0;
      orph_m <= 1'b0;
    end else begin
      if (mtag != 4'd0) begin
        if (owner_of[mtag] == 0) orph_m <= 1'b1;
        else owner_of[mtag] <= 0;
      end
      if (who_wins() != 0 && (who_wins() == 1 ? dcmd : icmd) == 2'd1 && mresp != 4'd0)
        owner_of[mresp] <= who_wins();
      denied <= (icmd != 2'd0 && who_wins() == 1) ? (denied < LIM ? denied + 1 : LIM) : 0;
    end
  end

  always @(negedge clock) begin
    int w, own;
    w = reset ? who_wins() : 0;
    own = (reset && mtag != 4'd0) ? owner_of[mtag] : 0;
    chk("m_pcmd", 64'(pcmd), 64'(w == 1 ? dcmd : w == 2 ? icmd : 2'd0));
    if (w != 0) begin
      chk("m_paddr", 64'(paddr), 64'(w == 1 ? daddr : iaddr));
      chk("m_pdata", pdata, w == 1 ? ddata : 64'd0);
    end
    chk("m_dresp", 64'(d_resp), 64'(w == 1 ? mresp : 4'd0));
    chk("m_iresp", 64'(i_resp), 64'(w == 2 ? mresp : 4'd0));
    chk("m_dtag", 64'(d_tag), 64'(own == 1 ? mtag : 4'd0));
    chk("m_itag", 64'(i_tag), 64'(own == 2 ? mtag : 4'd0));
    chk("m_ddata", d_data, mdata);
    chk("m_idata", i_data, mdata);
    chk("m_orphan", 64'(orphan), 64'(reset && orph_m));
  end

  task automatic drive(input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                       input logic [1:0] ic, input logic [31:0] ia,
                       input logic [3:0] rs, input logic [3:0] tg, input logic [63:0] md);
    @(posedge clock);
    #1;
    dcmd = dc; daddr = da; ddata = dd; icmd = ic; iaddr = ia;
    mresp = rs; mtag = tg; mdata = md;
    #1;
  endtask

  task automatic idle();
    drive(2'd0, 32'd0, 64'd0, 2'd0, 32'd0, 4'd0, 4'd0, 64'd0);
  endtask

  initial begin
    dcmd = 2'd0; icmd = 2'd0; daddr = '0; iaddr = '0; ddata = '0;
    mresp = '0; mtag = '0; mdata = '0;
    drive(2'd1, 32'h100, 64'h55, 2'd1, 32'h200, 4'd3, 4'd3, 64'h1);
    chk("rst_pcmd", 64'(pcmd), 64'd0);
    chk("rst_dresp", 64'(d_resp), 64'd0);
    chk("rst_iresp", 64'(i_resp), 64'd0);
    chk("rst_dtag", 64'(d_tag), 64'd0);
    chk("rst_orphan", 64'(orphan), 64'd0);
    idle();
    @(posedge clock);
    #1 reset = 1'b1;
    drive(2'd1, 32'h100, 64'd0, 2'd0, 32'd0, 4'd3, 4'd0, 64'd0);
    chk("dload_pcmd", 64'(pcmd), 64'd1);
    chk("dload_paddr", 64'(paddr), 64'h100);
    chk("dload_dresp", 64'(d_resp), 64'd3);
    chk("dload_iresp", 64'(i_resp), 64'd0);
    idle();
    drive(2'd0, 32'd0, 64'd0, 2'd0, 32'd0, 4'd0, 4'd3, 64'hDEAD);
    chk("dload_dtag", 64'(d_tag), 64'd3);
    chk("dload_ddata", d_data, 64'hDEAD);
    chk("dload_itag", 64'(i_tag), 64'd0);
    idle();
    drive(2'd1, 32'h200, 64'hAA, 2'd1, 32'h300, 4'd5, 4'd0, 64'd0);
    chk("cont_dresp", 64'(d_resp), 64'd5);
    chk("cont_iresp0", 64'(i_resp), 64'd0);
    chk("cont_paddr_d", 64'(paddr), 64'h200);
    drive(2'd0, 32'h200, 64'hAA, 2'd1, 32'h300, 4'd6, 4'd0, 64'd0);
    chk("cont_iresp", 64'(i_resp), 64'd6);
    chk("cont_paddr_i", 64'(paddr), 64'h300);
    chk("cont_pdata_i", pdata, 64'd0);
    drive(2'd0, 32'd0, 64'd0, 2'd0, 32'd0, 4'd0, 4'd6, 64'h66);
    chk("cont_itag6", 64'(i_tag), 64'd6);
    chk("cont_dtag6", 64'(d_tag), 64'd0);
    drive(2'd0, 32'd0, 64'd0, 2'd0, 32'd0, 4'd0, 4'd5, 64'h55);
    chk("cont_dtag5", 64'(d_tag), 64'd5);
    chk("cont_itag5", 64'(i_tag), 64'd0);
    idle();
    for (int k = 0; k < 10; k++) begin
      drive(2'd1, 32'h800, 64'd0, 2'd1, 32'h900, 4'd0, 4'd0, 64'd0);
      chk("starve_grant", 64'(paddr), (k % 5 == 4) ? 64'h900 : 64'h800);
    end
    idle();
    drive(2'd2, 32'h400, 64'h1234, 2'd0, 32'd0, 4'd7, 4'd0, 64'd0);
    chk("st_pcmd", 64'(pcmd), 64'd2);
    chk("st_pdata", pdata, 64'h1234);
    chk("st_dresp", 64'(d_resp), 64'd7);
    drive(2'd0, 32'd0, 64'd0, 2'd0, 32'd0, 4'd0, 4'd7, 64'h77);
    chk("st_dtag", 64'(d_tag), 64'd0);
    chk("st_itag", 64'(i_tag), 64'd0);
    chk("st_orphan_pre", 64'(orphan), 64'd0);
    idle();
    chk("st_orphan", 64'(orphan), 64'd1);
    drive(2'd1, 32'h500, 64'd0, 2'd0, 32'd0, 4'd2, 4'd0, 64'd0);
    idle();
    drive(2'd0, 32'd0, 64'd0, 2'd1, 32'h600, 4'd2, 4'd2, 64'h22);
    chk("reuse_dtag", 64'(d_tag), 64'd2);
    chk("reuse_itag0", 64'(i_tag), 64'd0);
    chk("reuse_iresp", 64'(i_resp), 64'd2);
    drive(2'd0, 32'd0, 64'd0, 2'd0, 32'd0, 4'd0, 4'd2, 64'h33);
    chk("reuse_itag", 64'(i_tag), 64'd2);
    chk("reuse_dtag0", 64'(d_tag), 64'd0);
    idle();
    drive(2'd1, 32'h700, 64'd0, 2'd0, 32'd0, 4'd4, 4'd0, 64'd0);
    chk("rmid_dresp", 64'(d_resp), 64'd4);
    idle();
    reset = 1'b0;
    #1;
    chk("rmid_orphan_clr", 64'(orphan), 64'd0);
    idle();
    @(posedge clock);
    #1 reset = 1'b1;
    drive(2'd0, 32'd0, 64'd0, 2'd0, 32'd0, 4'd0, 4'd4, 64'h44);
    chk("rmid_dtag", 64'(d_tag), 64'd0);
    chk("rmid_itag", 64'(i_tag), 64'd0);
    idle();
    chk("rmid_orphan", 64'(orphan), 64'd1);
    idle();
    @(posedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
